ring_carrier_osc: RTL and testbench

Sine carrier oscillator feeding the `ring_modulation` stage's 32-bit signed `sin` input. Phase-accumulator digital oscillator: advances once per audio sample strobe, converts phase to amplitude through a quarter-wave ROM, and presents a scaled, sign-extended carrier value with a one-cycle valid pulse. Carrier frequency is runtime-loadable from the effect control logic.

---
 rtl/audio_fx_pkg.sv | 32 +++
 rtl/sine_quarter_rom.sv | 29 ++
 rtl/ring_carrier_osc.sv | 144 ++++++++++++++
 tb/tb_ring_carrier_osc.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_fx_pkg.sv
// Shared definitions for the audio effect chain: default widths for the
// carrier oscillator, the Q15 full-scale constant, the phase quadrant type
// and the quarter-wave sine table generator.
package audio_fx_pkg;

    localparam int PHASE_W_DEF   = 24;
    localparam int ROM_AW_DEF    = 8;
    localparam int AMP_SHIFT_DEF = 11;

    localparam int Q15_W   = 15;
    localparam int Q15_MAX = 32767;

    // Top two phase bits select one quarter of the sine period.
    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quad_t;

    // Quarter-wave entry i of a table with 2^aw entries, sampled at the
    // middle of each step so that mirroring the address is exact and the
    // table never has to hold the +/-32768 end point.
    function automatic logic [Q15_W-1:0] sine_entry(input int i, input int aw);
        real ang;
        real mag;
        ang = ($itor(i) + 0.5) * 3.14159265358979323846 / $itor(2 ** (aw + 1));
        mag = $itor(Q15_MAX) * $sin(ang);
        return Q15_W'($rtoi(mag + 0.5));
    endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// Quarter-wave sine table with a registered read port. Contents are built
// at elaboration from sine_entry(); one clock of read latency.
module sine_quarter_rom
    import audio_fx_pkg::*;
#(
    parameter int ROM_AW = ROM_AW_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ROM_AW-1:0] addr,
    output logic [Q15_W-1:0]  data
);

    logic [Q15_W-1:0] rom_tab [2**ROM_AW];

    for (genvar i = 0; i < 2**ROM_AW; i++) begin : g_tab
        assign rom_tab[i] = sine_entry(i, ROM_AW);
    end

    // Registered table read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data <= '0;
        end else begin
            data <= rom_tab[addr];
        end
    end

endmodule

// File: rtl/ring_carrier_osc.sv
// Sine carrier oscillator for the ring modulator. A phase accumulator steps
// once per sample tick; the current phase is folded onto a quarter-wave
// table, the sign is restored, and the Q15 result is scaled down and
// sign-extended to 32 bits with a one-cycle valid pulse, three clocks later.
module ring_carrier_osc
    import audio_fx_pkg::*;
#(
    parameter int                 PHASE_W   = PHASE_W_DEF,
    parameter int                 ROM_AW    = ROM_AW_DEF,
    parameter int                 AMP_SHIFT = AMP_SHIFT_DEF,
    parameter logic [PHASE_W-1:0] RESET_INC = '0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                sample_tick,
    input  logic                enable,
    input  logic                phase_sync,
    input  logic                freq_load,
    input  logic [PHASE_W-1:0]  freq_inc,
    output logic signed [31:0]  sin_out,
    output logic                sin_valid
);

    // Restore the sign of a table magnitude as a signed Q15 value.
    function automatic logic signed [15:0] to_q15(input logic [Q15_W-1:0] mag,
                                                  input logic             neg);
        logic signed [15:0] v;
        v = $signed({1'b0, mag});
        return neg ? -v : v;
    endfunction

    // Arithmetic down-scale of a Q15 sample into the 32-bit carrier range;
    // the shift floors toward minus infinity, matching the downstream math.
    function automatic logic signed [31:0] scale_amp(input logic signed [15:0] v);
        logic signed [31:0] w;
        w = {{16{v[15]}}, v};
        return w >>> AMP_SHIFT;
    endfunction

    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] inc;
    logic [PHASE_W-1:0] phase_cur;
    logic [PHASE_W-1:0] phase_nxt;
    quad_t              quad_cur;
    logic [ROM_AW-1:0]  addr_cur;

    logic               vld_p0;
    logic               neg_p0;
    logic               zero_p0;
    logic [ROM_AW-1:0]  addr_p0;

    logic               vld_p1;
    logic               neg_p1;
    logic               zero_p1;
    logic [Q15_W-1:0]   rom_p1;

    logic               vld_p2;
    logic signed [31:0] sin_p2;

    // Phase seen by this cycle's lookup, its quadrant decode and the next phase.
    always_comb begin
        phase_cur = phase_sync ? '0 : phase;
        quad_cur  = quad_t'(phase_cur[PHASE_W-1 -: 2]);
        addr_cur  = phase_cur[PHASE_W-3 -: ROM_AW];
        if (quad_cur == Q1 || quad_cur == Q3) begin
            addr_cur = ~addr_cur;
        end
        phase_nxt = phase_cur;
        if (sample_tick && enable) begin
            phase_nxt = phase_cur + inc;
        end
    end

    // Phase accumulator and loadable increment; a load on a tick edge only
    // affects the following tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase <= '0;
            inc   <= RESET_INC;
        end else begin
            phase <= phase_nxt;
            if (freq_load) begin
                inc <= freq_inc;
            end
        end
    end

    // ---- stage p0: registered quadrant decode ----
    // Capture the folded table address and sign/zero flags of the current phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p0  <= 1'b0;
            neg_p0  <= 1'b0;
            zero_p0 <= 1'b0;
            addr_p0 <= '0;
        end else begin
            vld_p0  <= sample_tick;
            neg_p0  <= quad_cur[1];
            zero_p0 <= !enable;
            addr_p0 <= addr_cur;
        end
    end

    // ---- stage p1: table read ----
    sine_quarter_rom #(
        .ROM_AW (ROM_AW)
    ) u_rom (
        .clk     (clk),
        .reset_n (reset_n),
        .addr    (addr_p0),
        .data    (rom_p1)
    );

    // Carry the sign/zero flags alongside the table read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1  <= 1'b0;
            neg_p1  <= 1'b0;
            zero_p1 <= 1'b0;
        end else begin
            vld_p1  <= vld_p0;
            neg_p1  <= neg_p0;
            zero_p1 <= zero_p0;
        end
    end

    // ---- stage p2: sign, scale and present ----
    // Update the carrier only on a valid lookup; hold it between ticks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p2 <= 1'b0;
            sin_p2 <= '0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                sin_p2 <= zero_p1 ? '0 : scale_amp(to_q15(rom_p1, neg_p1));
            end
        end
    end

    assign sin_out   = sin_p2;
    assign sin_valid = vld_p2;

endmodule

// File: tb/tb_ring_carrier_osc.sv
// Bench for ring_carrier_osc: two instances (unscaled and default scaling)
// share one stimulus; a phase model predicts each tick's carrier value and
// due cycle, and a per-cycle monitor checks pulses and values.
module tb_ring_carrier_osc;

    localparam int PW = 24;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                sample_tick;
    logic                enable;
    logic                phase_sync;
    logic                freq_load;
    logic [PW-1:0]       freq_inc;
    logic signed [31:0]  sin0;
    logic signed [31:0]  sin11;
    logic                vld0;
    logic                vld11;

    always #5 clk = ~clk;

    ring_carrier_osc #(.AMP_SHIFT(0)) dut0 (
        .clk         (clk),
        .reset_n     (reset_n),
        .sample_tick (sample_tick),
        .enable      (enable),
        .phase_sync  (phase_sync),
        .freq_load   (freq_load),
        .freq_inc    (freq_inc),
        .sin_out     (sin0),
        .sin_valid   (vld0)
    );

    ring_carrier_osc dut11 (
        .clk         (clk),
        .reset_n     (reset_n),
        .sample_tick (sample_tick),
        .enable      (enable),
        .phase_sync  (phase_sync),
        .freq_load   (freq_load),
        .freq_inc    (freq_inc),
        .sin_out     (sin11),
        .sin_valid   (vld11)
    );

    typedef struct {
        int due;
        int v0;
        int v11;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    logic [PW-1:0] pm;
    logic [PW-1:0] im;

    // Full-period sine of a 24-bit phase, sampled at the centre of each of
    // 1024 steps, rounded half away from zero.
    function automatic int model_q15(input logic [PW-1:0] ph);
        int  j;
        real s;
        j = int'(ph >> (PW - 10));
        s = $sin(($itor(j) + 0.5) * 2.0 * 3.14159265358979323846 / 1024.0);
        if (s >= 0.0) return $rtoi(32767.0 * s + 0.5);
        else          return -$rtoi(-32767.0 * s + 0.5);
    endfunction

    function automatic int model_shift11(input int v);
        return $rtoi($floor($itor(v) / 2048.0));
    endfunction

    // Per-cycle monitor: a pulse exactly when the oldest prediction falls due.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            mon_e = sb.pop_front();
            checks++;
            if (vld0 !== 1'b1 || vld11 !== 1'b1) begin
                errors++;
                $display("FAIL valid_pulse cyc %0d: got %b/%b want 1/1", cyc, vld0, vld11);
            end
            checks++;
            if (sin0 !== mon_e.v0) begin
                errors++;
                $display("FAIL sin_shift0 cyc %0d: got %0d want %0d", cyc, sin0, mon_e.v0);
            end
            checks++;
            if (sin11 !== mon_e.v11) begin
                errors++;
                $display("FAIL sin_shift11 cyc %0d: got %0d want %0d", cyc, sin11, mon_e.v11);
            end
        end else begin
            checks++;
            if (vld0 !== 1'b0 || vld11 !== 1'b0) begin
                errors++;
                $display("FAIL no_pulse cyc %0d: got %b/%b want 0/0", cyc, vld0, vld11);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one cycle of inputs and advance the model accordingly.
    task automatic drive(input logic tk, input logic sy, input logic en,
                         input logic ld, input logic [PW-1:0] fi);
        logic [PW-1:0] lp;
        exp_t          e;
        @(negedge clk);
        sample_tick = tk;
        phase_sync  = sy;
        enable      = en;
        freq_load   = ld;
        freq_inc    = fi;
        lp = sy ? '0 : pm;
        if (tk) begin
            e.due = cyc + 3;
            e.v0  = en ? model_q15(lp) : 0;
            e.v11 = model_shift11(e.v0);
            sb.push_back(e);
            pm = en ? lp + im : lp;
        end else begin
            pm = lp;
        end
        if (ld) im = fi;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, freq_inc);
    endtask

    task automatic tick(input int gap);
        drive(1'b1, 1'b0, 1'b1, 1'b0, freq_inc);
        idle(gap);
    endtask

    task automatic load(input logic [PW-1:0] fi);
        drive(1'b0, 1'b0, 1'b1, 1'b1, fi);
        idle(1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 30 && sb.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d outputs outstanding, want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        sample_tick = 1'b0;
        enable      = 1'b1;
        phase_sync  = 1'b0;
        freq_load   = 1'b0;
        freq_inc    = '0;
        pm          = '0;
        im          = '0;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sin0 !== 32'sd0 || sin11 !== 32'sd0) begin
            errors++;
            $display("FAIL reset_sin: got %0d/%0d want 0/0", sin0, sin11);
        end
        checks++;
        if (vld0 !== 1'b0 || vld11 !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b/%b want 0/0", vld0, vld11);
        end
        @(negedge clk);
        reset_n = 1'b1;
        idle(2);
    endtask

    // Quarter-period steps hit the four quadrant edges: 101, 32767, -101, -32767.
    task automatic test_quadrants();
        load(24'h40_0000);
        for (int k = 0; k < 5; k++) tick(3);
        wait_drain();
    endtask

    // A load on the tick edge must not affect that tick's phase step.
    task automatic test_freq_load();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 24'h10_0000);
        idle(1);
        tick(1);
        tick(1);
        wait_drain();
    endtask

    task automatic test_sync_enable();
        drive(1'b1, 1'b1, 1'b1, 1'b0, freq_inc);
        idle(2);
        drive(1'b1, 1'b0, 1'b0, 1'b0, freq_inc);
        idle(2);
        tick(2);
        tick(2);
        drive(1'b0, 1'b1, 1'b1, 1'b0, freq_inc);
        tick(3);
        wait_drain();
    endtask

    task automatic test_freq_zero();
        load(24'h00_0000);
        tick(1);
        tick(1);
        tick(1);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        load(24'hD5_A5A5);
        for (int k = 0; k < 5; k++) drive(1'b1, 1'b0, 1'b1, 1'b0, freq_inc);
        idle(1);
        wait_drain();
    endtask

    task automatic test_reset_midpipe();
        load(24'h40_0000);
        drive(1'b1, 1'b0, 1'b1, 1'b0, freq_inc);
        drive(1'b1, 1'b0, 1'b1, 1'b0, freq_inc);
        @(negedge clk);
        sample_tick = 1'b0;
        reset_n     = 1'b0;
        sb.delete();
        #1;
        checks++;
        if (sin0 !== 32'sd0 || sin11 !== 32'sd0 || vld0 !== 1'b0 || vld11 !== 1'b0) begin
            errors++;
            $display("FAIL reset_midpipe: got %0d/%0d vld %b/%b want 0/0 vld 0/0",
                     sin0, sin11, vld0, vld11);
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        pm      = '0;
        im      = '0;
        idle(6);
        tick(2);
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_quadrants();
        test_freq_load();
        test_sync_enable();
        test_freq_zero();
        test_back_to_back();
        test_reset_midpipe();
        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
